// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event strobes into fixed-width high windows separated by a
// guaranteed low gap; events arriving while a window is active are queued in a saturating counter.
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_pulse,
    output logic              out_level,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int MAX_CYCLES = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);

    if (HIGH_CYCLES < 1 || GAP_CYCLES < 1 || PEND_W < 1) begin : g_param_err
        $error("pulse_stretcher: HIGH_CYCLES, GAP_CYCLES and PEND_W must all be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            state_q;
    logic [TW-1:0]     timer_q;
    logic              out_level_q;
    logic              busy_q;
    logic [PEND_W-1:0] pending_q;
    logic              overflow_q;

    logic last_gap_d;
    logic queue_evt_d;
    logic pend_full_d;

    // The event seen on the last gap cycle is never queued: it either starts the next
    // window itself or stands in for the queued event that does.
    assign last_gap_d  = (state_q == ST_GAP) && (timer_q == '0);
    assign queue_evt_d = in_pulse && ((state_q == ST_HIGH) || ((state_q == ST_GAP) && !last_gap_d));
    assign pend_full_d = &pending_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            out_level_q <= 1'b0;
            busy_q      <= 1'b0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            if (queue_evt_d) begin
                if (pend_full_d) begin
                    overflow_q <= 1'b1;
                end else begin
                    pending_q <= pending_q + PEND_W'(1);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (in_pulse) begin
                        state_q     <= ST_HIGH;
                        timer_q     <= TW'(HIGH_CYCLES - 1);
                        out_level_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (timer_q == '0) begin
                        state_q     <= ST_GAP;
                        timer_q     <= TW'(GAP_CYCLES - 1);
                        out_level_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                ST_GAP: begin
                    if (!last_gap_d) begin
                        timer_q <= timer_q - TW'(1);
                    end else if ((pending_q != '0) || in_pulse) begin
                        state_q     <= ST_HIGH;
                        timer_q     <= TW'(HIGH_CYCLES - 1);
                        out_level_q <= 1'b1;
                        if ((pending_q != '0) && !in_pulse) begin
                            pending_q <= pending_q - PEND_W'(1);
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    timer_q     <= '0;
                    out_level_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign out_level = out_level_q;
    assign busy      = busy_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule
